// File: rtl/accum_sequencer.sv
// accum_sequencer: replays a stored {op,operand} program into the accumulator ALU.
// Ports: clk/rst_n, prog_* write port, start/prog_len/loops/abort, acc_* ALU drive, pc, busy/done/wr_err.
module accum_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_op,
  input  logic [W-1:0]  prog_operand,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic [LW-1:0] loops,
  input  logic          abort,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [1:0]    acc_op,
  output logic [W-1:0]  acc_operand,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);

  typedef enum logic [1:0] {
    IDLE, CLEAR, RUN, DONE
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state, nstate;
  logic [AW-1:0] npc;
  logic [LW-1:0] loop_cnt, nloop;
  logic [LW-1:0] loops_q;
  logic [AW:0]   len_q;
  logic [AW:0]   len_clamp;
  logic [1:0]    mem_op  [DEPTH];
  logic [W-1:0]  mem_opd [DEPTH];
  logic          take_start;
  logic          last_entry;
  logic          more_passes;
  logic          we_ok;

  assign take_start = (state == IDLE) && start && !abort;
  assign we_ok = (state == IDLE) || (state == DONE);
  assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_entry = ({1'b0, pc} == len_q - (AW+1)'(1));
  assign more_passes =
    ({1'b0, loop_cnt} + (LW+1)'(1)) < {1'b0, loops_q};

  always_comb begin
    nstate = state;
    npc    = pc;
    nloop  = loop_cnt;
    unique case (state)
      IDLE: begin
        if (take_start) begin
          nstate = CLEAR;
          npc    = '0;
          nloop  = '0;
        end
      end
      CLEAR: begin
        if (abort)
          nstate = IDLE;
        else if (len_q != '0)
          nstate = RUN;
        else
          nstate = DONE;
      end
      RUN: begin
        if (abort) begin
          nstate = IDLE;
          npc    = '0;
        end else if (!last_entry) begin
          npc = pc + AW'(1);
        end else if (more_passes) begin
          npc   = '0;
          nloop = loop_cnt + LW'(1);
        end else begin
          nstate = DONE;
        end
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      loop_cnt    <= '0;
      loops_q     <= '0;
      len_q       <= '0;
      wr_err      <= 1'b0;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      acc_op      <= '0;
      acc_operand <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i]  <= '0;
        mem_opd[i] <= '0;
      end
    end else begin
      state    <= nstate;
      pc       <= npc;
      loop_cnt <= nloop;
      if (take_start) begin
        len_q   <= len_clamp;
        loops_q <= (loops == '0) ? LW'(1) : loops;
        wr_err  <= 1'b0;
      end else if (prog_we && !we_ok) begin
        wr_err <= 1'b1;
      end
      if (prog_we && we_ok) begin
        mem_op[prog_addr]  <= prog_op;
        mem_opd[prog_addr] <= prog_operand;
      end
      acc_clr <= (nstate == CLEAR);
      acc_en  <= (nstate == RUN);
      busy    <= (nstate == CLEAR) || (nstate == RUN);
      done    <= (nstate == DONE);
      // Writes never land while CLEAR/RUN, so mem is stable here.
      acc_op      <= (nstate == RUN) ? mem_op[npc] : '0;
      acc_operand <= (nstate == RUN) ? mem_opd[npc] : '0;
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: scoreboard bench for accum_sequencer.
// Driver pushes expected clr/issue/done events; a negedge monitor pops and compares.
module tb_accum_sequencer;
  localparam int W = 8, DEPTH = 8, AW = 3, LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_op;
  logic [W-1:0]  prog_operand;
  logic          start;
  logic [AW:0]   prog_len;
  logic [LW-1:0] loops;
  logic          abort;
  logic          acc_clr, acc_en, busy, done, wr_err;
  logic [1:0]    acc_op;
  logic [W-1:0]  acc_operand;
  logic [AW-1:0] pc;

  accum_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_op(prog_op), .prog_operand(prog_operand), .start(start),
    .prog_len(prog_len), .loops(loops), .abort(abort),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_op(acc_op),
    .acc_operand(acc_operand), .pc(pc), .busy(busy), .done(done),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = clear, 1 = issue, 2 = done
  typedef struct {
    int       kind;
    int       cyc;
    logic [1:0] op;
    logic [7:0] opd;
    int       pc;
    logic [7:0] acc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b1;
  logic [1:0] m_op  [DEPTH];
  logic [7:0] m_opd [DEPTH];
  logic [7:0] acc_m = '0;

  function automatic logic [7:0] alu(logic [7:0] a, logic [1:0] op,
                                     logic [7:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  int   mk;
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (acc_clr) acc_m = '0;
      else if (acc_en) acc_m = alu(acc_m, acc_op, acc_operand);
      if (acc_clr || acc_en || done) begin
        mk = acc_clr ? 0 : (acc_en ? 1 : 2);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: kind %0d at cycle %0d, required none",
                   mk, cyc);
        end else begin
          me = q.pop_front();
          check("kind", mk, me.kind);
          check("cycle", cyc, me.cyc);
          check("busy", int'(busy), int'(me.kind != 2));
          if (mk == 1) begin
            check("acc_op", int'(acc_op), int'(me.op));
            check("acc_operand", int'(acc_operand), int'(me.opd));
            check("pc", int'(pc), me.pc);
            check("alu_acc", int'(acc_m), int'(me.acc));
          end
        end
      end
    end
  end

  // Expected event stream of one run, from the program model.
  task automatic push_run(int e, int len, int lp, int max_iss);
    int L, N, k;
    logic [7:0] acc;
    exp_t x;
    L = (len > DEPTH) ? DEPTH : len;
    N = (lp == 0) ? 1 : lp;
    x = '{kind: 0, cyc: e, op: 2'd0, opd: 8'd0, pc: 0, acc: 8'd0};
    q.push_back(x);
    acc = '0;
    k = 0;
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < L; i++) begin
        if (max_iss < 0 || k < max_iss) begin
          acc = alu(acc, m_op[i], m_opd[i]);
          x = '{kind: 1, cyc: e + 1 + k, op: m_op[i], opd: m_opd[i],
                pc: i, acc: acc};
          q.push_back(x);
        end
        k++;
      end
    end
    if (max_iss < 0) begin
      x = '{kind: 2, cyc: e + 1 + L * N, op: 2'd0, opd: 8'd0,
            pc: 0, acc: 8'd0};
      q.push_back(x);
    end
  endtask

  task automatic write_entry(int a, logic [1:0] op, logic [7:0] d);
    @(negedge clk);
    prog_we      = 1'b1;
    prog_addr    = AW'(a);
    prog_op      = op;
    prog_operand = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    m_op[a]  = op;
    m_opd[a] = d;
  endtask

  task automatic launch(int len, int lp, output int e);
    @(negedge clk);
    prog_len = (AW+1)'(len);
    loops    = LW'(lp);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = cyc;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d events pending, required 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int e, e2, rl, rp;

  initial begin
    rst_n = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_op = '0;
    prog_operand = '0;
    start = 1'b0;
    prog_len = '0;
    loops = '0;
    abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_op[i] = '0;
      m_opd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_acc_en", int'(acc_en), 0);
    check("rst_acc_clr", int'(acc_clr), 0);
    check("rst_done", int'(done), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_wr_err", int'(wr_err), 0);
    check("rst_acc_op", int'(acc_op), 0);
    check("rst_acc_operand", int'(acc_operand), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic program
    write_entry(0, 2'd0, 8'h05);
    write_entry(1, 2'd1, 8'h02);
    write_entry(2, 2'd3, 8'hFF);
    launch(3, 2, e);
    push_run(e, 3, 2, -1);
    drain();
    check("basic_final_acc", int'(acc_m), 8'h00);

    // edge lengths
    launch(0, 1, e);
    push_run(e, 0, 1, -1);
    drain();
    launch(15, 0, e);
    push_run(e, 15, 0, -1);
    drain();

    // random programs
    repeat (6) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, 2'($urandom_range(0, 3)), 8'($urandom));
      rl = $urandom_range(0, 15);
      rp = $urandom_range(0, 3);
      launch(rl, rp, e);
      push_run(e, rl, rp, -1);
      drain();
    end

    // abort on 3rd RUN cycle
    launch(8, 2, e);
    push_run(e, 8, 2, 3);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_acc_en", int'(acc_en), 0);
    check("abort_done", int'(done), 0);
    drain();

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_clr", int'(acc_clr), 0);
    drain();

    // write while busy is dropped and flagged
    write_entry(1, 2'd0, 8'h11);
    launch(4, 1, e);
    push_run(e, 4, 1, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 3'd1;
    prog_op = 2'd3;
    prog_operand = 8'hAA;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    check("wr_err_set", int'(wr_err), 1);
    drain();
    check("wr_err_held", int'(wr_err), 1);
    launch(4, 1, e);
    push_run(e, 4, 1, -1);
    check("wr_err_cleared", int'(wr_err), 0);
    drain();

    // write and start in the same cycle
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 3'd2;
    prog_op = 2'd1;
    prog_operand = 8'h33;
    prog_len = 4'd3;
    loops = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    start = 1'b0;
    e = cyc;
    m_op[2] = 2'd1;
    m_opd[2] = 8'h33;
    push_run(e, 3, 1, -1);
    drain();

    // start held high: next run begins from IDLE after DONE
    @(negedge clk);
    prog_len = 4'd2;
    loops = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    push_run(e, 2, 2, -1);
    e2 = e + 2 * 2 + 3;
    push_run(e2, 2, 2, -1);
    while (cyc < e2) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    drain();

    // reset mid-run restores entries to {ADD,0}
    mon_en = 1'b0;
    launch(8, 15, e);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_acc_en", int'(acc_en), 0);
    check("midrst_pc", int'(pc), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_op[i] = '0;
      m_opd[i] = '0;
    end
    mon_en = 1'b1;
    launch(8, 1, e);
    push_run(e, 8, 1, -1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
